// File: rtl/psg_frame_writer_if.sv
// Byte-stream input and PSG register-bus output bundle for psg_frame_writer.
// master: the writer (consumes the stream, drives the PSG bus).
// slave: the stream source and the PSG core taken together.
interface psg_frame_writer_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] psg_addr;
  logic [7:0] psg_din;
  logic       psg_cs_n;
  logic       psg_wr_n;

  modport master (
    input  s_data, s_valid,
    output s_ready, psg_addr, psg_din, psg_cs_n, psg_wr_n
  );

  modport slave (
    output s_data, s_valid,
    input  s_ready, psg_addr, psg_din, psg_cs_n, psg_wr_n
  );
endinterface

// File: rtl/psg_frame_writer.sv
// PSG frame writer: buffers one 14-byte register frame from a valid/ready
// stream and, on each frame tick, replays R0..R13 onto the PSG bus with
// individually shaped write strobes.
module psg_frame_writer #(
  parameter int unsigned FRAME_DIV = 70000,
  parameter int unsigned WR_HOLD   = 2,
  parameter bit          SKIP_FF13 = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              enable,
  psg_frame_writer_if.master bus,
  output logic              busy,
  output logic              frame_tick,
  output logic              underrun,
  output logic              overrun,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned DW = $clog2(FRAME_DIV);
  localparam int unsigned HW = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_NEXT
  } state_e;

  state_e        state_q;
  logic [3:0]    reg_q;
  logic [3:0]    idx_q;
  logic [7:0]    frame_q [14];
  logic          full_q;
  logic          s_ready_q;
  logic [3:0]    addr_q;
  logic [7:0]    din_q;
  logic          cs_n_q;
  logic          wr_n_q;
  logic          busy_q;
  logic [15:0]   cnt_q;
  logic [DW-1:0] div_q;
  logic [HW-1:0] hold_q;
  logic          tick_q;
  logic          under_q;
  logic          over_q;

  logic          take;
  logic          fill_done;
  logic          tick_hit;
  logic          start;
  logic          last_reg;
  logic          seq_done;
  logic          full_d;
  logic          idle_d;
  logic          s_ready_d;
  logic [3:0]    reg_nxt;

  // Handshake, tick and sequencing conditions shared by the register blocks.
  always_comb begin
    take      = bus.s_valid && s_ready_q;
    fill_done = take && (idx_q == 4'd13);
    tick_hit  = enable && clk_en && (div_q == DW'(FRAME_DIV - 1));
    start     = tick_hit && (state_q == S_IDLE) && full_q;
    last_reg  = (reg_q == 4'd13) ||
                (SKIP_FF13 && (reg_q == 4'd12) && (frame_q[13] == 8'hFF));
    seq_done  = (state_q == S_NEXT) && last_reg;
    reg_nxt   = reg_q + 4'd1;
    full_d    = full_q;
    if (seq_done) begin
      full_d = 1'b0;
    end else if (fill_done) begin
      full_d = 1'b1;
    end
    // s_ready is registered, so it is derived from the next full/idle state
    idle_d    = ((state_q == S_IDLE) && !start) || seq_done;
    s_ready_d = !full_d && idle_d;
  end

  // Frame buffer: store each accepted byte at the current load index.
  always_ff @(posedge clk) begin
    if (take) begin
      frame_q[idx_q] <= bus.s_data;
    end
  end

  // Frame divider: count clk_en pulses while enabled and flag tick outcomes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      under_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      tick_q  <= tick_hit;
      under_q <= tick_hit && (state_q == S_IDLE) && !full_q;
      over_q  <= tick_hit && (state_q != S_IDLE);
      if (!enable) begin
        div_q <= '0;
      end else if (clk_en) begin
        div_q <= tick_hit ? '0 : div_q + DW'(1);
      end
    end
  end

  // Load control and write sequencer with registered PSG bus outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      reg_q     <= '0;
      hold_q    <= '0;
      idx_q     <= '0;
      full_q    <= 1'b0;
      s_ready_q <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      cs_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      full_q    <= full_d;
      s_ready_q <= s_ready_d;
      if (take) begin
        idx_q <= fill_done ? 4'd0 : idx_q + 4'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_SETUP;
            reg_q   <= '0;
            addr_q  <= '0;
            din_q   <= frame_q[0];
            cs_n_q  <= 1'b0;
            wr_n_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_SETUP: begin
          state_q <= S_STROBE;
          hold_q  <= '0;
          wr_n_q  <= 1'b0;
        end
        S_STROBE: begin
          if (hold_q == HW'(WR_HOLD - 1)) begin
            state_q <= S_HOLD;
            wr_n_q  <= 1'b1;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        S_HOLD: begin
          state_q <= S_NEXT;
        end
        S_NEXT: begin
          if (last_reg) begin
            state_q <= S_IDLE;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= cnt_q + 16'd1;
          end else begin
            state_q <= S_SETUP;
            reg_q   <= reg_nxt;
            addr_q  <= reg_nxt;
            din_q   <= frame_q[reg_nxt];
          end
        end
        default: begin
          state_q <= S_IDLE;
          cs_n_q  <= 1'b1;
          wr_n_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ready  = s_ready_q;
  assign bus.psg_addr = addr_q;
  assign bus.psg_din  = din_q;
  assign bus.psg_cs_n = cs_n_q;
  assign bus.psg_wr_n = wr_n_q;
  assign busy         = busy_q;
  assign frame_tick   = tick_q;
  assign underrun     = under_q;
  assign overrun      = over_q;
  assign frame_cnt    = cnt_q;

endmodule

// File: tb/tb_psg_frame_writer.sv
// Directed bench for psg_frame_writer (FRAME_DIV=4, WR_HOLD=2, SKIP_FF13=1).
module tb_psg_frame_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic        enable = 1'b0;
  logic        busy;
  logic        frame_tick;
  logic        underrun;
  logic        overrun;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  // per-sequence observations
  logic [3:0] w_addr [16];
  logic [7:0] w_din  [16];
  int         w_len  [16];
  int         n_wr;
  int         busy_cyc;
  int         cs_bad;
  int         unstable;

  psg_frame_writer_if bus ();

  psg_frame_writer #(
    .FRAME_DIV(4),
    .WR_HOLD  (2),
    .SKIP_FF13(1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .enable    (enable),
    .bus       (bus),
    .busy      (busy),
    .frame_tick(frame_tick),
    .underrun  (underrun),
    .overrun   (overrun),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    int w;
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    w = 0;
    while (!bus.s_ready && w < 100) begin
      step();
      w++;
    end
    if (!bus.s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: s_ready=%0b required 1", bus.s_ready);
    end
    step();
    bus.s_valid = 1'b0;
  endtask

  task automatic load_frame(input logic [7:0] base, input int first, input int n, input bit ff13);
    for (int i = first; i < first + n; i++) begin
      send_byte((i == 13 && ff13) ? 8'hFF : 8'(base + i));
    end
  endtask

  // four consecutive clk_en pulses from a zero divider produce one tick
  task automatic fire_tick();
    enable = 1'b1;
    clk_en = 1'b1;
    repeat (4) step();
    clk_en = 1'b0;
    enable = 1'b0;
  endtask

  task automatic capture_seq();
    logic       prev_wr;
    logic [3:0] a0;
    logic [7:0] d0;
    int         low;
    int         c;
    n_wr = 0; busy_cyc = 0; cs_bad = 0; unstable = 0;
    prev_wr = 1'b1; low = 0; c = 0; a0 = '0; d0 = '0;
    while (busy === 1'b1 && c < 200) begin
      busy_cyc++;
      if (bus.psg_cs_n !== 1'b0) cs_bad++;
      if (bus.psg_wr_n === 1'b0) begin
        if (prev_wr) begin
          a0 = bus.psg_addr;
          d0 = bus.psg_din;
          low = 0;
        end
        low++;
        if (bus.psg_addr !== a0 || bus.psg_din !== d0) unstable++;
      end else if (!prev_wr) begin
        if (bus.psg_addr !== a0 || bus.psg_din !== d0) unstable++;
        if (n_wr < 16) begin
          w_addr[n_wr] = a0;
          w_din[n_wr]  = d0;
          w_len[n_wr]  = low;
        end
        n_wr++;
      end
      prev_wr = bus.psg_wr_n;
      step();
      c++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL capture_timeout: busy=%0b required 0", busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    checks++; if (bus.psg_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %0b want 1", bus.psg_cs_n); end
    checks++; if (bus.psg_wr_n !== 1'b1) begin errors++; $display("FAIL reset_wr_n: got %0b want 1", bus.psg_wr_n); end
    checks++; if (bus.psg_addr !== 4'd0) begin errors++; $display("FAIL reset_addr: got %0h want 0", bus.psg_addr); end
    checks++; if (bus.psg_din !== 8'd0) begin errors++; $display("FAIL reset_din: got %0h want 0", bus.psg_din); end
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %0b want 0", bus.s_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (frame_tick !== 1'b0 || underrun !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: got %0b%0b%0b want 000", frame_tick, underrun, overrun);
    end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    rst_n = 1'b1;
    step();
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL release_s_ready: got %0b want 1", bus.s_ready); end
  endtask

  task automatic test_full_frame();
    load_frame(8'h10, 0, 14, 1'b0);
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL full_s_ready: got %0b want 0", bus.s_ready); end
    fire_tick();
    checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL full_tick: got %0b want 1", frame_tick); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy_start: got %0b want 1", busy); end
    capture_seq();
    checks++; if (busy_cyc != 70) begin errors++; $display("FAIL full_busy_len: got %0d want 70", busy_cyc); end
    checks++; if (n_wr != 14) begin errors++; $display("FAIL full_nwr: got %0d want 14", n_wr); end
    checks++; if (cs_bad != 0) begin errors++; $display("FAIL full_cs_low: got %0d high cycles want 0", cs_bad); end
    checks++; if (unstable != 0) begin errors++; $display("FAIL full_stable: got %0d changes want 0", unstable); end
    for (int i = 0; i < 14 && i < n_wr; i++) begin
      checks++; if (w_addr[i] !== 4'(i)) begin errors++; $display("FAIL full_addr[%0d]: got %0d want %0d", i, w_addr[i], i); end
      checks++; if (w_din[i] !== 8'(8'h10 + i)) begin errors++; $display("FAIL full_din[%0d]: got %0h want %0h", i, w_din[i], 8'(8'h10 + i)); end
      checks++; if (w_len[i] != 2) begin errors++; $display("FAIL full_wr_len[%0d]: got %0d want 2", i, w_len[i]); end
    end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL full_frame_cnt: got %0d want 1", frame_cnt); end
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL full_s_ready_after: got %0b want 1", bus.s_ready); end
    checks++; if (bus.psg_cs_n !== 1'b1 || bus.psg_wr_n !== 1'b1) begin
      errors++; $display("FAIL full_idle_strobes: got cs_n=%0b wr_n=%0b want 1 1", bus.psg_cs_n, bus.psg_wr_n);
    end
    checks++; if (bus.psg_addr !== 4'd13 || bus.psg_din !== 8'h1D) begin
      errors++; $display("FAIL full_idle_hold: got %0h/%0h want d/1d", bus.psg_addr, bus.psg_din);
    end
  endtask

  task automatic test_underrun();
    load_frame(8'h20, 0, 5, 1'b0);
    fire_tick();
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL under_pulse: got %0b want 1", underrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL under_busy: got %0b want 0", busy); end
    checks++; if (bus.psg_cs_n !== 1'b1 || bus.psg_wr_n !== 1'b1) begin
      errors++; $display("FAIL under_strobes: got cs_n=%0b wr_n=%0b want 1 1", bus.psg_cs_n, bus.psg_wr_n);
    end
    step();
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL under_width: got %0b want 0", underrun); end
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL under_s_ready: got %0b want 1", bus.s_ready); end
    load_frame(8'h20, 5, 9, 1'b0);
    fire_tick();
    capture_seq();
    checks++; if (n_wr != 14) begin errors++; $display("FAIL under_nwr: got %0d want 14", n_wr); end
    checks++; if (busy_cyc != 70) begin errors++; $display("FAIL under_busy_len: got %0d want 70", busy_cyc); end
    checks++; if (w_din[0] !== 8'h20 || w_din[13] !== 8'h2D) begin
      errors++; $display("FAIL under_din: got %0h..%0h want 20..2d", w_din[0], w_din[13]);
    end
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL under_frame_cnt: got %0d want 2", frame_cnt); end
  endtask

  task automatic test_skip_ff13();
    int n13;
    load_frame(8'h30, 0, 14, 1'b1);
    fire_tick();
    capture_seq();
    n13 = 0;
    for (int i = 0; i < n_wr && i < 16; i++) if (w_addr[i] === 4'd13) n13++;
    checks++; if (busy_cyc != 65) begin errors++; $display("FAIL skip_busy_len: got %0d want 65", busy_cyc); end
    checks++; if (n_wr != 13) begin errors++; $display("FAIL skip_nwr: got %0d want 13", n_wr); end
    checks++; if (n13 != 0) begin errors++; $display("FAIL skip_addr13: got %0d writes want 0", n13); end
    checks++; if (w_addr[12] !== 4'd12 || w_din[12] !== 8'h3C) begin
      errors++; $display("FAIL skip_last: got %0h/%0h want c/3c", w_addr[12], w_din[12]);
    end
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL skip_frame_cnt: got %0d want 3", frame_cnt); end
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL skip_s_ready: got %0b want 1", bus.s_ready); end
  endtask

  task automatic test_overrun();
    int   nt, no, nu, nrise, t0, t1, w;
    logic pb;
    nt = 0; no = 0; nu = 0; nrise = 0; t0 = -1; t1 = -1;
    load_frame(8'h60, 0, 14, 1'b0);
    pb = busy;
    enable = 1'b1;
    for (int c = 0; c < 48; c++) begin
      clk_en = (c % 3 == 0);
      step();
      if (frame_tick === 1'b1) begin
        if (nt == 0) t0 = c;
        else if (nt == 1) t1 = c;
        nt++;
      end
      if (overrun === 1'b1) no++;
      if (underrun === 1'b1) nu++;
      if (busy === 1'b1 && pb !== 1'b1) nrise++;
      pb = busy;
    end
    clk_en = 1'b0;
    enable = 1'b0;
    w = 0;
    while (busy === 1'b1 && w < 200) begin
      step();
      w++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovr_timeout: busy=%0b want 0", busy); end
    checks++; if (t0 != 9) begin errors++; $display("FAIL ovr_first_tick: got %0d want 9", t0); end
    checks++; if (t1 - t0 != 12) begin errors++; $display("FAIL ovr_period: got %0d want 12", t1 - t0); end
    checks++; if (nt != 4) begin errors++; $display("FAIL ovr_ticks: got %0d want 4", nt); end
    checks++; if (no != 3) begin errors++; $display("FAIL ovr_overruns: got %0d want 3", no); end
    checks++; if (nu != 0) begin errors++; $display("FAIL ovr_underruns: got %0d want 0", nu); end
    checks++; if (nrise != 1) begin errors++; $display("FAIL ovr_sequences: got %0d want 1", nrise); end
    checks++; if (frame_cnt !== 16'd4) begin errors++; $display("FAIL ovr_frame_cnt: got %0d want 4", frame_cnt); end
  endtask

  task automatic test_reset_mid();
    int w;
    load_frame(8'h70, 0, 14, 1'b0);
    fire_tick();
    w = 0;
    while (!(bus.psg_addr === 4'd6 && bus.psg_wr_n === 1'b0) && w < 100) begin
      step();
      w++;
    end
    checks++; if (bus.psg_addr !== 4'd6 || bus.psg_wr_n !== 1'b0) begin
      errors++; $display("FAIL mid_reach_strobe6: got addr=%0d wr_n=%0b want 6 0", bus.psg_addr, bus.psg_wr_n);
    end
    rst_n = 1'b0;
    step();
    checks++; if (bus.psg_cs_n !== 1'b1 || bus.psg_wr_n !== 1'b1) begin
      errors++; $display("FAIL mid_strobes: got cs_n=%0b wr_n=%0b want 1 1", bus.psg_cs_n, bus.psg_wr_n);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %0b want 0", busy); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL mid_frame_cnt: got %0d want 0", frame_cnt); end
    checks++; if (bus.psg_addr !== 4'd0) begin errors++; $display("FAIL mid_addr: got %0d want 0", bus.psg_addr); end
    rst_n = 1'b1;
    step();
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL mid_s_ready: got %0b want 1", bus.s_ready); end
    load_frame(8'h40, 0, 14, 1'b0);
    fire_tick();
    capture_seq();
    checks++; if (n_wr != 14) begin errors++; $display("FAIL mid_nwr: got %0d want 14", n_wr); end
    checks++; if (w_addr[0] !== 4'd0 || w_din[0] !== 8'h40) begin
      errors++; $display("FAIL mid_first: got %0h/%0h want 0/40", w_addr[0], w_din[0]);
    end
    checks++; if (w_din[13] !== 8'h4D) begin errors++; $display("FAIL mid_last: got %0h want 4d", w_din[13]); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL mid_frame_cnt_after: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_back_to_back();
    int   acc;
    logic took;
    acc = 0;
    bus.s_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      bus.s_data = 8'(8'h50 + acc);
      took = bus.s_ready;
      step();
      if (took === 1'b1) acc++;
    end
    bus.s_valid = 1'b0;
    checks++; if (acc != 14) begin errors++; $display("FAIL b2b_accepted: got %0d want 14", acc); end
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL b2b_s_ready_full: got %0b want 0", bus.s_ready); end
    fire_tick();
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL b2b_s_ready_busy: got %0b want 0", bus.s_ready); end
    capture_seq();
    checks++; if (n_wr != 14) begin errors++; $display("FAIL b2b_nwr: got %0d want 14", n_wr); end
    checks++; if (w_din[0] !== 8'h50 || w_din[13] !== 8'h5D) begin
      errors++; $display("FAIL b2b_din: got %0h..%0h want 50..5d", w_din[0], w_din[13]);
    end
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL b2b_frame_cnt: got %0d want 2", frame_cnt); end
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL b2b_s_ready_after: got %0b want 1", bus.s_ready); end
  endtask

  initial begin
    bus.s_data  = 8'h00;
    bus.s_valid = 1'b0;
    test_reset();
    test_full_frame();
    test_underrun();
    test_skip_ff13();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psg_frame_writer.md
Name: psg_frame_writer

Overview:
- Bus initiator for the PSG register interface. It drives addr, din, cs_n and wr_n into the PSG core.
- Accepts register frames over a valid/ready byte stream. A frame is 14 bytes: registers R0..R13 in order.
- Buffers one frame, then on each frame tick writes all 14 registers to the PSG with correctly shaped write strobes.
- Sits between a music-data source (CPU, SD/ROM streamer) and the PSG. It replaces a CPU for frame-based tune playback.

Parameters:
- FRAME_DIV, 70000: number of clk_en pulses per frame tick. Must be at least 2.
- WR_HOLD, 2: number of clk cycles psg_wr_n is held low per register write. Must be at least 1.
- SKIP_FF13, 1: when 1, the R13 write is skipped if its buffered value is 8'hFF. This leaves the envelope untouched and not restarted.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- clk_en  in  1  PSG clock enable; advances the frame divider only.
- enable  in  1  playback enable.
- s_data  in  8  frame byte.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  writer accepts a byte this cycle.
- psg_addr  out  4  PSG register address.
- psg_din  out  8  PSG write data.
- psg_cs_n  out  1  PSG chip select, active low.
- psg_wr_n  out  1  PSG write strobe, active low.
- busy  out  1  a write sequence is in progress.
- frame_tick  out  1  one-cycle pulse at each frame boundary.
- underrun  out  1  one-cycle pulse when a tick finds no full frame buffered.
- overrun  out  1  one-cycle pulse when a tick arrives while busy.
- frame_cnt  out  16  count of completed frame write sequences; wraps modulo 2^16.

Behaviour:
- Reset (rst_n low at a clk edge) gives:
  - psg_cs_n=1, psg_wr_n=1, psg_addr=0, psg_din=0.
  - s_ready=0, busy=0, frame_tick=0, underrun=0, overrun=0, frame_cnt=0.
  - Load index=0, buffer empty, divider=0, FSM in IDLE.
- Reset applied mid-sequence aborts the sequence. The strobes are high on the very next edge.
- Load path:
  - s_ready=1 whenever the buffer is not full and the FSM is not in a write state.
  - A byte is taken when s_valid and s_ready are both high. It is stored at the load index, and the index then increments.
  - When byte 13 is taken, the buffer becomes full on the next edge, the index resets to 0, and s_ready drops.
  - s_ready stays 0 while busy.
- Frame divider:
  - Counts clk_en pulses while enable=1.
  - On the clk_en where count==FRAME_DIV-1: count returns to 0 and frame_tick pulses for 1 clk.
  - enable=0 holds the count at 0. A sequence already in progress still completes.
- On a tick:
  - If IDLE and the buffer is full: start a sequence, busy=1 from the next cycle.
  - If IDLE and not full: underrun pulses and no write occurs.
  - If busy: overrun pulses and the tick is dropped.
  - "Full" is the registered flag. If the last byte is taken in the same cycle as the tick, the result is an underrun.
- Write FSM states are IDLE, SETUP, STROBE, HOLD, NEXT. It runs every clk, not gated by clk_en.
  - SETUP (1 cycle): psg_addr=r, psg_din=buf[r], psg_cs_n=0, psg_wr_n=1.
  - STROBE (WR_HOLD cycles): psg_wr_n=0; addr and din stable.
  - HOLD (1 cycle): psg_wr_n=1, psg_cs_n=0, addr and din stable.
  - NEXT: r increments. If r was 13: the buffer is emptied, frame_cnt increments, the FSM goes to IDLE, and busy=0 on the following cycle.
  - psg_cs_n returns high between registers only in IDLE. Each write gets its own wr_n low-to-high edge, which the PSG's envelope-restart edge detector relies on.
- R13 skip: if SKIP_FF13=1 and buf[13]==8'hFF, reg 13 is skipped. NEXT goes straight to completion and no strobe is issued for addr 13.
- Sequence length:
  - With no skip: 14 × (WR_HOLD+2) cycles plus 1 NEXT per register. That is 70 cycles at WR_HOLD=2.
  - With the R13 skip: 65 cycles.
- psg_addr and psg_din hold their last values in IDLE.
- Registers 14 and 15 are never written.

Test Plan:
- Load bytes 8'h10..8'h1D, then force a tick -> 14 strobes with addr 0..13 and din 10..1D; each wr_n low for exactly 2 clk; cs_n low throughout; frame_cnt=1; s_ready=1 after busy falls.
- Tick with only 5 bytes loaded -> underrun is a 1-clk pulse; cs_n and wr_n stay high; a later full load plus tick writes normally.
- Frame with byte 13 = 8'hFF and SKIP_FF13=1 -> 13 strobes with addr 0..12; no addr 13 write; busy lasts 65 cycles.
- FRAME_DIV=4, clk_en every 3rd clk, enable=1 -> frame_tick every 12 clk; a second tick landing during a sequence gives an overrun pulse and exactly one sequence.
- rst_n low during STROBE of reg 6 -> next edge cs_n=1, wr_n=1, busy=0, frame_cnt=0; after release s_ready=1 and the load index restarts at 0.
- Hold s_valid=1 with no tick -> exactly 14 bytes accepted, then s_ready=0 until a sequence completes.
